// File: rtl/char_uart_rx.sv
// 8N1 serial receiver feeding the character recogniser: mid-bit sampling,
// start-glitch rejection, framing-error pulse and break hold-off.
module char_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rxd,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  // IDLE: line idle | START: confirm start at mid-bit | DATA: 8 data bits
  // STOP: check stop bit | WAIT_HIGH: bad stop, hold off until line releases
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t          state_q;
  logic [1:0]      sync_q;
  logic [CW-1:0]   clk_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      char_q;
  logic            valid_q;
  logic            err_q;
  logic            rxd_s;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      char_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_q   <= START;
            clk_cnt_q <= '0;
          end
        end
        START: begin
          if (clk_cnt_q == CNT_HALF) begin
            clk_cnt_q <= '0;
            if (!rxd_s) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q          <= '0;
            shift_q[bit_cnt_q] <= rxd_s;
            if (bit_cnt_q == 3'd7) begin
              state_q   <= STOP;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            if (rxd_s) begin
              char_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != IDLE);

endmodule
